agu_access_scheduler: RTL and testbench
=======================================

// Module: agu_access_scheduler
// PURPOSE
// Shares the single address_generation_unit between NREQ requesters (fetch, load/store, debug).
// Round-robin arbitration; issues one AGU operation per grant.
// Sequences the optional pointer writeback to the register file for post-inc/pre-dec modes.
// Returns the computed address to the granted requester.
// PARAMETERS
// NREQ       3   number of requesters (legal 2..4)
// ADDR_W     16  address / pointer width
// REG_W      3   register index width
// OFF_W      8   offset width
// TIMEOUT    16  max WAIT cycles for agu_done before error response
// PORTS
// clk         in   1             system clock, rising edge
// a_reset     in   1             asynchronous reset, active-high
// req         in   NREQ          request per requester, held until ack
// req_mode    in   2*NREQ        per requester: 00 direct, 01 indirect, 10 post-inc, 11 pre-dec
// req_reg     in   REG_W*NREQ    per requester base register index
// req_off     in   OFF_W*NREQ    per requester offset
// ack         out  NREQ          one-cycle done pulse to granted requester
// rsp_addr    out  ADDR_W        result address, valid with ack
// rsp_err     out  1             timeout flag, valid with ack
// busy        out  1             state != IDLE
// agu_start   out  1             one-cycle AGU launch
// agu_mode    out  2             latched mode to AGU
// agu_reg     out  REG_W         latched register index to AGU
// agu_off     out  OFF_W         latched offset to AGU
// agu_done    in   1             AGU result valid
// agu_addr    in   ADDR_W        AGU effective address
// agu_upd     in   ADDR_W        AGU updated pointer value
// rf_we       out  1             register-file pointer write enable
// rf_sel      out  REG_W         register-file write index
// rf_wdata    out  ADDR_W        register-file write data
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, rr_ptr=0, all outputs 0, latched fields 0; no partial writeback.
// - FSM states: IDLE -> ISSUE -> WAIT -> [WB] -> RESP -> IDLE.
// - IDLE: if |req, grant g = first set req at or after rr_ptr (wrapping).
//   Latch mode/reg/off of g, clear wait counter, go to ISSUE. No req: stay.
// - ISSUE: agu_start=1 for exactly this cycle; agu_mode/reg/off hold latched values until return to IDLE. Go to WAIT.
//   agu_done during ISSUE is ignored.
// - WAIT: on agu_done, capture agu_addr and agu_upd; mode 1x -> WB, else -> RESP.
//   Else counter+1; when counter reaches TIMEOUT-1 without done: rsp_addr=0, rsp_err=1, go to RESP (no WB).
// - WB: rf_we=1 one cycle, rf_sel=latched reg, rf_wdata=captured agu_upd. Go to RESP.
// - RESP: ack[g]=1 one cycle; rsp_addr/rsp_err valid this cycle only (0 otherwise).
//   rr_ptr <= (g+1) mod NREQ. Go to IDLE.
// - Latency (req seen in IDLE at cycle T, done in first WAIT cycle): direct/indirect ack at T+3, post-inc/pre-dec ack at T+4.
// - Back-to-back: a request present in the IDLE cycle after RESP is granted there; min 4-cycle grant spacing.
// - req dropped after grant: operation and writeback still complete, ack still pulses.
// - req of a non-granted requester never affects latched fields.
// - Outputs registered; ack never asserts to more than one requester.
// TESTING
// - req[0] direct, agu_done first WAIT cycle, agu_addr=0x1234 -> ack[0] at T+3, rsp_addr=0x1234, rsp_err=0, rf_we never.
// - req[1] mode 10 reg 3 off 0x02, agu_upd=0x0102 -> rf_we one cycle, rf_sel=3, rf_wdata=0x0102, ack[1] next cycle (T+4).
// - req=3'b111 held, one-cycle AGU -> ack order 0,1,2,0,1 with 4-cycle spacing.
// - req[2] with agu_done held 0 -> ack[2] after 16 WAIT cycles, rsp_err=1, rsp_addr=0, no rf_we.
// - a_reset=1 during WAIT of a post-inc op -> all outputs 0 same cycle, no rf_we.
//   After release, req=3'b110 granted to requester 1 first.
// - req[0] dropped in WAIT, agu_done arrives -> ack[0] still pulses, then IDLE, busy=0.

Source files
------------

// File: rtl/agu_access_scheduler.sv
// Round-robin scheduler sharing one AGU between NREQ requesters, with pointer writeback.
// Ack at T+3 (direct/indirect) or T+4 (post-inc/pre-dec); requests hold until acked, non-winners wait.
module agu_access_scheduler #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 3,
  parameter int OFF_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    a_reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_mode,
  input  logic [REG_W*NREQ-1:0]   req_reg,
  input  logic [OFF_W*NREQ-1:0]   req_off,
  output logic [NREQ-1:0]         ack,
  output logic [ADDR_W-1:0]       rsp_addr,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    agu_start,
  output logic [1:0]              agu_mode,
  output logic [REG_W-1:0]        agu_reg,
  output logic [OFF_W-1:0]        agu_off,
  input  logic                    agu_done,
  input  logic [ADDR_W-1:0]       agu_addr,
  input  logic [ADDR_W-1:0]       agu_upd,
  output logic                    rf_we,
  output logic [REG_W-1:0]        rf_sel,
  output logic [ADDR_W-1:0]       rf_wdata
);

  localparam int GW = (NREQ > 2) ? 2 : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, RESP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [1:0]        mode_q, mode_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              start_d, rsp_err_d, rf_we_d;
  logic [NREQ-1:0]   ack_d;
  logic [ADDR_W-1:0] rsp_addr_d, rf_wdata_d;
  logic [REG_W-1:0]  rf_sel_d;

  logic              found;
  logic [GW-1:0]     gsel;

  // Scan from the lowest rotated offset last so the requester nearest rr_q wins.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_q) + i) % NREQ]) begin
        found = 1'b1;
        gsel  = GW'((int'(rr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    mode_d     = mode_q;
    reg_d      = reg_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    start_d    = 1'b0;
    ack_d      = '0;
    rsp_addr_d = '0;
    rsp_err_d  = 1'b0;
    rf_we_d    = 1'b0;
    rf_sel_d   = '0;
    rf_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = gsel;
          mode_d  = req_mode[2*int'(gsel) +: 2];
          reg_d   = req_reg[REG_W*int'(gsel) +: REG_W];
          off_d   = req_off[OFF_W*int'(gsel) +: OFF_W];
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (agu_done) begin
          addr_d = agu_addr;
          if (mode_q[1]) begin
            rf_we_d    = 1'b1;
            rf_sel_d   = reg_q;
            rf_wdata_d = agu_upd;
            state_d    = WB;
          end else begin
            ack_d[grant_q] = 1'b1;
            rsp_addr_d     = agu_addr;
            state_d        = RESP;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Timed-out ops answer with an error and skip the pointer writeback.
          addr_d         = '0;
          ack_d[grant_q] = 1'b1;
          rsp_err_d      = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        ack_d[grant_q] = 1'b1;
        rsp_addr_d     = addr_q;
        state_d        = RESP;
      end
      RESP: begin
        rr_d    = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      mode_q    <= '0;
      reg_q     <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      agu_start <= 1'b0;
      ack       <= '0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
      rf_we     <= 1'b0;
      rf_sel    <= '0;
      rf_wdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      mode_q    <= mode_d;
      reg_q     <= reg_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      agu_start <= start_d;
      ack       <= ack_d;
      rsp_addr  <= rsp_addr_d;
      rsp_err   <= rsp_err_d;
      rf_we     <= rf_we_d;
      rf_sel    <= rf_sel_d;
      rf_wdata  <= rf_wdata_d;
      busy      <= (state_d != IDLE);
    end
  end

  assign agu_mode = mode_q;
  assign agu_reg  = reg_q;
  assign agu_off  = off_q;

endmodule

// File: tb/tb_agu_access_scheduler.sv
// Directed bench for agu_access_scheduler with a simple one-cycle AGU responder.
module tb_agu_access_scheduler;
  logic        clk = 1'b0;
  logic        a_reset;
  logic [2:0]  req;
  logic [5:0]  req_mode;
  logic [8:0]  req_reg;
  logic [23:0] req_off;
  logic [2:0]  ack;
  logic [15:0] rsp_addr;
  logic        rsp_err;
  logic        busy;
  logic        agu_start;
  logic [1:0]  agu_mode;
  logic [2:0]  agu_reg;
  logic [7:0]  agu_off;
  logic        agu_done;
  logic [15:0] agu_addr;
  logic [15:0] agu_upd;
  logic        rf_we;
  logic [2:0]  rf_sel;
  logic [15:0] rf_wdata;

  agu_access_scheduler dut (
    .clk(clk), .a_reset(a_reset), .req(req), .req_mode(req_mode), .req_reg(req_reg),
    .req_off(req_off), .ack(ack), .rsp_addr(rsp_addr), .rsp_err(rsp_err), .busy(busy),
    .agu_start(agu_start), .agu_mode(agu_mode), .agu_reg(agu_reg), .agu_off(agu_off),
    .agu_done(agu_done), .agu_addr(agu_addr), .agu_upd(agu_upd), .rf_we(rf_we),
    .rf_sel(rf_sel), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          we_cyc = 0;
  logic [2:0]  we_sel;
  logic [15:0] we_dat;
  logic        agu_auto = 1'b1;
  logic        done_next = 1'b0;
  int          lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and play the AGU.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rf_we) begin
      we_cnt++;
      we_cyc = cyc;
      we_sel = rf_sel;
      we_dat = rf_wdata;
    end
    agu_done  = agu_auto & done_next;
    done_next = agu_start;
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 3'b000 && n < budget);
    if (ack == 3'b000) chk("ack_timeout", 32'(n), 32'(budget + 1));
  endtask

  initial begin
    a_reset  = 1'b1;
    req      = '0;
    req_mode = '0;
    req_reg  = '0;
    req_off  = '0;
    agu_done = 1'b0;
    agu_addr = '0;
    agu_upd  = '0;
    we_sel   = '0;
    we_dat   = '0;
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0;

    // Reset state
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_start", 32'(agu_start), 32'h0);
    chk("rst_rsp_addr", 32'(rsp_addr), 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_agu_mode", 32'(agu_mode), 32'h0);

    // Direct access from requester 0
    agu_addr = 16'h1234;
    agu_upd  = 16'h5555;
    req      = 3'b001;
    we_cnt   = 0;
    wait_ack(30, lat);
    chk("dir_lat", 32'(lat), 32'd3);
    chk("dir_ack", 32'(ack), 32'h1);
    chk("dir_addr", 32'(rsp_addr), 32'h1234);
    chk("dir_err", 32'(rsp_err), 32'h0);
    req = 3'b000;
    tick();
    chk("dir_ack_off", 32'(ack), 32'h0);
    chk("dir_addr_off", 32'(rsp_addr), 32'h0);
    chk("dir_busy_off", 32'(busy), 32'h0);
    chk("dir_no_we", 32'(we_cnt), 32'h0);

    // Post-increment from requester 1 with writeback
    req_mode = 6'b00_10_00;
    req_reg  = 9'b000_011_000;
    req_off  = 24'h00_02_00;
    agu_addr = 16'h0200;
    agu_upd  = 16'h0102;
    req      = 3'b010;
    tick();
    chk("pi_start", 32'(agu_start), 32'h1);
    chk("pi_mode", 32'(agu_mode), 32'h2);
    chk("pi_reg", 32'(agu_reg), 32'h3);
    chk("pi_off", 32'(agu_off), 32'h02);
    wait_ack(30, lat);
    chk("pi_lat", 32'(lat + 1), 32'd4);
    chk("pi_ack", 32'(ack), 32'h2);
    chk("pi_addr", 32'(rsp_addr), 32'h0200);
    chk("pi_we_cnt", 32'(we_cnt), 32'h1);
    chk("pi_we_sel", 32'(we_sel), 32'h3);
    chk("pi_we_dat", 32'(we_dat), 32'h0102);
    chk("pi_we_then_ack", 32'(cyc - we_cyc), 32'h1);
    req = 3'b000;
    tick();

    // Timeout on requester 2 (post-inc mode, so a skipped writeback is visible)
    req_mode = 6'b10_00_00;
    agu_auto = 1'b0;
    agu_addr = 16'hBEEF;
    we_cnt   = 0;
    req      = 3'b100;
    wait_ack(40, lat);
    chk("to_lat", 32'(lat), 32'd18);
    chk("to_ack", 32'(ack), 32'h4);
    chk("to_err", 32'(rsp_err), 32'h1);
    chk("to_addr", 32'(rsp_addr), 32'h0);
    req = 3'b000;
    tick();
    chk("to_err_off", 32'(rsp_err), 32'h0);
    chk("to_no_we", 32'(we_cnt), 32'h0);
    agu_auto = 1'b1;

    // All three requesting: rotation 0,1,2,0,1 with 4-cycle spacing
    req_mode = '0;
    req      = 3'b111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(30, lat);
      chk($sformatf("rr_ack%0d", k), 32'(ack), 32'(3'b001 << (k % 3)));
      chk($sformatf("rr_lat%0d", k), 32'(lat), (k == 0) ? 32'd3 : 32'd4);
    end
    req = 3'b000;
    tick();

    // Reset during WAIT of a post-inc op
    req_mode = 6'b00_10_00;
    agu_auto = 1'b0;
    we_cnt   = 0;
    req      = 3'b010;
    tick();
    tick();
    chk("ar_busy_pre", 32'(busy), 32'h1);
    a_reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_start", 32'(agu_start), 32'h0);
    chk("ar_mode", 32'(agu_mode), 32'h0);
    chk("ar_reg", 32'(agu_reg), 32'h0);
    chk("ar_ack", 32'(ack), 32'h0);
    agu_done = 1'b1;
    tick();
    tick();
    chk("ar_no_we", 32'(we_cnt), 32'h0);
    agu_auto = 1'b1;
    a_reset  = 1'b0;
    req      = 3'b110;
    wait_ack(30, lat);
    chk("ar_first_grant", 32'(ack), 32'h2);
    req = 3'b000;
    tick();

    // Request dropped while waiting for the AGU
    req_mode = '0;
    agu_addr = 16'h0ABC;
    req      = 3'b001;
    tick();
    tick();
    req = 3'b000;
    tick();
    chk("drop_ack", 32'(ack), 32'h1);
    chk("drop_addr", 32'(rsp_addr), 32'h0ABC);
    tick();
    chk("drop_busy", 32'(busy), 32'h0);
    tick();
    chk("drop_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
